// File: rtl/controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback plus ALU decoder.
// Latency: one state per clock; outputs follow the state register, pcen/alucontrol also follow zero/funct combinationally.
// Backpressure: none; the FSM advances every cycle, synchronous active-high reset returns it to FETCH.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode; everything defaults to inactive.
  always_comb begin
    w_next    = FETCH;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_aluop   = 2'b00;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    case (r_state)
      FETCH: begin
        w_next    = DECODE;
        alusrcb   = 2'b01;
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Only lw and sw reach here; anything other than lw is the store path.
        w_next  = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord   = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
        w_next  = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // ALU decoder: fixed add/sub for address and branch, funct field for R-type.
  always_comb begin
    alucontrol = 4'b0010;
    case (w_aluop)
      2'b01: alucontrol = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 4'b0010;
          6'b100010: alucontrol = 4'b0110;
          6'b100100: alucontrol = 4'b0000;
          6'b100101: alucontrol = 4'b0001;
          6'b101010: alucontrol = 4'b0111;
          6'b100111: alucontrol = 4'b1100;
          default:   alucontrol = 4'b0010;
        endcase
      end
      default: alucontrol = 4'b0010;
    endcase
  end

  assign pcen = w_pcwrite | (w_branch & zero);

endmodule

// File: tb/tb_controller.sv
// Directed, table-driven bench for the multi-cycle MIPS controller.
// Each vector is one clock: inputs applied after the rising edge, outputs compared at the falling edge.
// A few hand sequences cover combinational pcen/alucontrol changes within a single state.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  int tests = 0;
  int fails = 0;

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // Output bundle: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
  logic [15:0] obs;
  assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  localparam logic [15:0] E_FETCH   = {8'b1010_0000, 2'b01, 2'b00, 4'b0010};
  localparam logic [15:0] E_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 4'b0010};
  localparam logic [15:0] E_MEMADR  = {8'b0000_1000, 2'b10, 2'b00, 4'b0010};
  localparam logic [15:0] E_MEMRD   = {8'b0000_0100, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] E_MEMWB   = {8'b0001_0010, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] E_MEMWR   = {8'b0100_0100, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] E_RTYPEWB = {8'b0001_0001, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] E_ADDIEX  = {8'b0000_1000, 2'b10, 2'b00, 4'b0010};
  localparam logic [15:0] E_ADDIWB  = {8'b0001_0000, 2'b00, 2'b00, 4'b0010};
  localparam logic [15:0] E_JEX     = {8'b1000_0000, 2'b00, 2'b10, 4'b0010};

  function automatic logic [15:0] e_rtypeex(input logic [3:0] alu);
    return {8'b0000_1000, 2'b00, 2'b00, alu};
  endfunction

  function automatic logic [15:0] e_beqex(input logic z);
    return {z, 7'b000_1000, 2'b00, 2'b01, 4'b0110};
  endfunction

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic [15:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(input logic [15:0] exp, input string name);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, obs, exp);
    end
  endtask

  // One clock with the given inputs; compare mid-cycle, then advance past the next edge.
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [15:0] e, input string n);
    reset = r; op = o; funct = f; zero = z;
    @(negedge clk);
    check(e, n);
    @(posedge clk);
    #1;
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [3:0] alu, input string n);
    add(0, RT, f, 0, E_FETCH,      {n, "_fetch"});
    add(0, RT, f, 0, E_DECODE,     {n, "_decode"});
    add(0, RT, f, 0, e_rtypeex(alu), {n, "_ex"});
    add(0, RT, f, 0, E_RTYPEWB,    {n, "_wb"});
  endtask

  initial begin
    reset = 1'b1; op = RT; funct = 6'b100000; zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: stays in FETCH.
    add(1, LW, 6'b0, 0, E_FETCH, "reset_held");
    // R-type add.
    add_rtype(6'b100000, 4'b0010, "radd");
    // lw: 5 cycles.
    add(0, LW, 6'b0, 0, E_FETCH,  "lw_fetch");
    add(0, LW, 6'b0, 0, E_DECODE, "lw_decode");
    add(0, LW, 6'b0, 0, E_MEMADR, "lw_memadr");
    add(0, SW, 6'b0, 0, E_MEMRD,  "lw_memrd_opchg");
    add(0, SW, 6'b0, 0, E_MEMWB,  "lw_memwb");
    // sw: 4 cycles; op changing in MEMWR is ignored.
    add(0, SW, 6'b0, 0, E_FETCH,  "sw_fetch");
    add(0, SW, 6'b0, 0, E_DECODE, "sw_decode");
    add(0, SW, 6'b0, 0, E_MEMADR, "sw_memadr");
    add(0, RT, 6'b0, 0, E_MEMWR,  "sw_memwr");
    // beq taken and not taken.
    add(0, BEQ, 6'b0, 1, E_FETCH,    "beq1_fetch");
    add(0, BEQ, 6'b0, 1, E_DECODE,   "beq1_decode");
    add(0, BEQ, 6'b0, 1, e_beqex(1), "beq1_ex");
    add(0, BEQ, 6'b0, 0, E_FETCH,    "beq0_fetch");
    add(0, BEQ, 6'b0, 0, E_DECODE,   "beq0_decode");
    add(0, BEQ, 6'b0, 0, e_beqex(0), "beq0_ex");
    // j.
    add(0, J, 6'b0, 0, E_FETCH,  "j_fetch");
    add(0, J, 6'b0, 0, E_DECODE, "j_decode");
    add(0, J, 6'b0, 0, E_JEX,    "j_ex");
    // Undefined opcode: 2 cycles.
    add(0, BAD, 6'b0, 0, E_FETCH,  "bad_fetch");
    add(0, BAD, 6'b0, 0, E_DECODE, "bad_decode");
    // addi.
    add(0, ADDI, 6'b0, 0, E_FETCH,  "addi_fetch");
    add(0, ADDI, 6'b0, 0, E_DECODE, "addi_decode");
    add(0, ADDI, 6'b0, 0, E_ADDIEX, "addi_ex");
    add(0, ADDI, 6'b0, 0, E_ADDIWB, "addi_wb");
    // funct sweep, including an unknown funct.
    add_rtype(6'b100010, 4'b0110, "rsub");
    add_rtype(6'b100100, 4'b0000, "rand");
    add_rtype(6'b100101, 4'b0001, "ror");
    add_rtype(6'b101010, 4'b0111, "rslt");
    add_rtype(6'b100111, 4'b1100, "rnor");
    add_rtype(6'b000000, 4'b0010, "runk");
    // Reset asserted in MEMRD aborts the load.
    add(0, LW, 6'b0, 0, E_FETCH,  "rst_fetch");
    add(0, LW, 6'b0, 0, E_DECODE, "rst_decode");
    add(0, LW, 6'b0, 0, E_MEMADR, "rst_memadr");
    add(1, LW, 6'b0, 0, E_MEMRD,  "rst_in_memrd");
    add(0, LW, 6'b0, 0, E_FETCH,  "rst_after_memrd");
    add(0, LW, 6'b0, 0, E_DECODE, "rst_restart_decode");
    add(0, LW, 6'b0, 0, E_MEMADR, "rst_restart_memadr");
    add(0, LW, 6'b0, 0, E_MEMRD,  "rst_restart_memrd");
    add(0, LW, 6'b0, 0, E_MEMWB,  "rst_restart_memwb");

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].exp, vecs[i].name);

    // pcen follows zero combinationally inside BEQEX.
    cyc(0, BEQ, 6'b0, 0, E_FETCH,  "comb_beq_fetch");
    cyc(0, BEQ, 6'b0, 0, E_DECODE, "comb_beq_decode");
    zero = 1'b0; #1; check(e_beqex(0), "comb_beq_z0");
    zero = 1'b1; #1; check(e_beqex(1), "comb_beq_z1");
    zero = 1'b0; #1; check(e_beqex(0), "comb_beq_z0_again");
    @(posedge clk); #1;

    // alucontrol follows funct combinationally inside RTYPEEX.
    cyc(0, RT, 6'b100000, 0, E_FETCH,  "comb_r_fetch");
    cyc(0, RT, 6'b100000, 0, E_DECODE, "comb_r_decode");
    funct = 6'b100000; #1; check(e_rtypeex(4'b0010), "comb_r_add");
    funct = 6'b101010; #1; check(e_rtypeex(4'b0111), "comb_r_slt");
    funct = 6'b100111; #1; check(e_rtypeex(4'b1100), "comb_r_nor");
    @(posedge clk); #1;
    cyc(0, RT, 6'b100111, 0, E_RTYPEWB, "comb_r_wb");
    cyc(0, RT, 6'b100111, 0, E_FETCH,   "comb_r_back_fetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
